// File: rtl/registro_universal.sv
// rtl/registro_universal.sv - WIDTH-bit universal register: hold, load, shift, rotate, inc/dec with wrap pulse
module registro_universal #(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qnot,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic             zero,
    output logic             wrap
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHR  = 3'b010,
        MODE_SHL  = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ROL  = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } mode_t;

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    // Serial inputs are only referenced in their own shift mode, so junk on them elsewhere never reaches q.
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        case (mode_t'(mode))
            MODE_HOLD: q_next = q;
            MODE_LOAD: q_next = d;
            MODE_SHR:  q_next = {ser_in_r, q[WIDTH-1:1]};
            MODE_SHL:  q_next = {q[WIDTH-2:0], ser_in_l};
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_INC: begin
                q_next    = q + 1'b1;
                wrap_next = &q;
            end
            MODE_DEC: begin
                q_next    = q - 1'b1;
                wrap_next = ~|q;
            end
            default: q_next = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= RESET_VAL;
            wrap <= 1'b0;
        end else if (en) begin
            q    <= q_next;
            wrap <= wrap_next;
        end else begin
            wrap <= 1'b0;
        end
    end

    assign qnot      = ~q;
    assign ser_out_r = q[0];
    assign ser_out_l = q[WIDTH-1];
    assign zero      = ~|q;

endmodule

// File: tb/tb_registro_universal.sv
// tb/tb_registro_universal.sv - table-driven bench for registro_universal
module tb_registro_universal;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, en, ser_in_r, ser_in_l;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic [W-1:0] q, qnot, q2, qnot2;
    logic         sor, sol, zero, wrap, sor2, sol2, zero2, wrap2;

    int n_checks = 0;
    int n_fail   = 0;

    registro_universal #(.WIDTH(W), .RESET_VAL(8'hA5)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .ser_in_r(ser_in_r), .ser_in_l(ser_in_l),
        .q(q), .qnot(qnot), .ser_out_r(sor), .ser_out_l(sol),
        .zero(zero), .wrap(wrap)
    );

    registro_universal #(.WIDTH(W), .RESET_VAL(8'h00)) dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .ser_in_r(ser_in_r), .ser_in_l(ser_in_l),
        .q(q2), .qnot(qnot2), .ser_out_r(sor2), .ser_out_l(sol2),
        .zero(zero2), .wrap(wrap2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         en;
        logic [2:0]   mode;
        logic [W-1:0] d;
        logic         sir;
        logic         sil;
        logic         pre_chk;
        logic         pre_sor;
        logic [W-1:0] exp_q;
        logic         exp_wrap;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic e, input logic [2:0] m,
                                input logic [W-1:0] dd, input logic sr, input logic sl,
                                input logic pc, input logic ps,
                                input logic [W-1:0] eq, input logic ew);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.d = dd; v.sir = sr; v.sil = sl;
        v.pre_chk = pc; v.pre_sor = ps; v.exp_q = eq; v.exp_wrap = ew;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one vector on the falling edge, take one rising edge, check on the next falling edge.
    task automatic step(input vec_t v, input string tag);
        rst = v.rst; en = v.en; mode = v.mode; d = v.d;
        ser_in_r = v.sir; ser_in_l = v.sil;
        #1;
        if (v.pre_chk) check({tag, " ser_out_r pre"}, {31'd0, sor}, {31'd0, v.pre_sor});
        @(posedge clk);
        @(negedge clk);
        check({tag, " q"},         {24'd0, q},    {24'd0, v.exp_q});
        check({tag, " qnot"},      {24'd0, qnot}, {24'd0, ~v.exp_q});
        check({tag, " zero"},      {31'd0, zero}, {31'd0, (v.exp_q == 8'h00)});
        check({tag, " ser_out_r"}, {31'd0, sor},  {31'd0, v.exp_q[0]});
        check({tag, " ser_out_l"}, {31'd0, sol},  {31'd0, v.exp_q[W-1]});
        check({tag, " wrap"},      {31'd0, wrap}, {31'd0, v.exp_wrap});
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; mode = 3'b000; d = '0; ser_in_r = 1'b0; ser_in_l = 1'b0;

        //                 rst en  mode    d      sir   sil  pc   ps   exp_q  wrap
        vecs.push_back(mk(1, 0, 3'b000, 8'h00, 0, 0, 0, 0, 8'hA5, 0));
        vecs.push_back(mk(0, 1, 3'b000, 8'h00, 0, 0, 0, 0, 8'hA5, 0));
        vecs.push_back(mk(0, 1, 3'b000, 8'hFF, 1, 1, 0, 0, 8'hA5, 0));
        vecs.push_back(mk(0, 1, 3'b000, 8'h00, 1, 0, 0, 0, 8'hA5, 0));
        vecs.push_back(mk(0, 1, 3'b001, 8'h81, 0, 0, 0, 0, 8'h81, 0));
        vecs.push_back(mk(0, 1, 3'b010, 8'h00, 1, 0, 1, 1, 8'hC0, 0));
        vecs.push_back(mk(0, 1, 3'b010, 8'h00, 1, 0, 1, 0, 8'hE0, 0));
        vecs.push_back(mk(0, 1, 3'b010, 8'h00, 1, 0, 1, 0, 8'hF0, 0));
        vecs.push_back(mk(0, 1, 3'b010, 8'h00, 1, 0, 1, 0, 8'hF8, 0));
        vecs.push_back(mk(0, 1, 3'b010, 8'h00, 1, 0, 1, 0, 8'hFC, 0));
        vecs.push_back(mk(0, 1, 3'b010, 8'h00, 1, 0, 1, 0, 8'hFE, 0));
        vecs.push_back(mk(0, 1, 3'b010, 8'h00, 1, 0, 1, 0, 8'hFF, 0));
        vecs.push_back(mk(0, 1, 3'b010, 8'h00, 1, 0, 1, 1, 8'hFF, 0));
        vecs.push_back(mk(0, 1, 3'b001, 8'h81, 0, 0, 0, 0, 8'h81, 0));
        vecs.push_back(mk(0, 1, 3'b101, 8'h00, 0, 1, 0, 0, 8'h03, 0));
        vecs.push_back(mk(0, 1, 3'b101, 8'h00, 0, 0, 0, 0, 8'h06, 0));
        vecs.push_back(mk(0, 1, 3'b101, 8'h00, 0, 0, 0, 0, 8'h0C, 0));
        vecs.push_back(mk(0, 1, 3'b101, 8'h00, 0, 0, 0, 0, 8'h18, 0));
        vecs.push_back(mk(0, 1, 3'b101, 8'h00, 0, 0, 0, 0, 8'h30, 0));
        vecs.push_back(mk(0, 1, 3'b101, 8'h00, 0, 0, 0, 0, 8'h60, 0));
        vecs.push_back(mk(0, 1, 3'b101, 8'h00, 0, 0, 0, 0, 8'hC0, 0));
        vecs.push_back(mk(0, 1, 3'b101, 8'h00, 0, 0, 0, 0, 8'h81, 0));
        vecs.push_back(mk(0, 1, 3'b011, 8'h00, 1, 0, 0, 0, 8'h02, 0));
        vecs.push_back(mk(0, 1, 3'b011, 8'h00, 0, 1, 0, 0, 8'h05, 0));
        vecs.push_back(mk(0, 1, 3'b100, 8'h00, 0, 0, 0, 0, 8'h82, 0));
        vecs.push_back(mk(0, 1, 3'b001, 8'hFE, 0, 0, 0, 0, 8'hFE, 0));
        vecs.push_back(mk(0, 1, 3'b110, 8'h00, 0, 0, 0, 0, 8'hFF, 0));
        vecs.push_back(mk(0, 1, 3'b110, 8'h00, 0, 0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 1, 3'b111, 8'h00, 0, 0, 0, 0, 8'hFF, 1));
        vecs.push_back(mk(0, 1, 3'b000, 8'h00, 0, 0, 0, 0, 8'hFF, 0));
        vecs.push_back(mk(0, 1, 3'b111, 8'h00, 0, 0, 0, 0, 8'hFE, 0));
        vecs.push_back(mk(0, 1, 3'b001, 8'h10, 0, 0, 0, 0, 8'h10, 0));
        vecs.push_back(mk(0, 0, 3'b110, 8'h00, 0, 0, 0, 0, 8'h10, 0));
        vecs.push_back(mk(0, 0, 3'b110, 8'h00, 0, 0, 0, 0, 8'h10, 0));
        vecs.push_back(mk(0, 0, 3'b110, 8'h00, 0, 0, 0, 0, 8'h10, 0));
        vecs.push_back(mk(0, 0, 3'b110, 8'h00, 0, 0, 0, 0, 8'h10, 0));
        vecs.push_back(mk(0, 1, 3'b001, 8'hFF, 0, 0, 0, 0, 8'hFF, 0));
        vecs.push_back(mk(0, 1, 3'b110, 8'h00, 0, 0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 3'b110, 8'h00, 0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 3'b001, 8'hFF, 0, 0, 0, 0, 8'hFF, 0));
        vecs.push_back(mk(0, 1, 3'b110, 8'h00, 0, 0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 1, 3'b001, 8'hFF, 0, 0, 0, 0, 8'hFF, 0));
        vecs.push_back(mk(0, 1, 3'b110, 8'h00, 0, 0, 0, 0, 8'h00, 1));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("v%0d", i));

        // Reset in the middle of a shift run, then the run resumes from RESET_VAL.
        step(mk(0, 1, 3'b001, 8'h3C, 0, 0, 0, 0, 8'h3C, 0), "seq load");
        step(mk(0, 1, 3'b010, 8'h00, 0, 0, 0, 0, 8'h1E, 0), "seq shr1");
        step(mk(0, 1, 3'b010, 8'h00, 0, 0, 0, 0, 8'h0F, 0), "seq shr2");
        step(mk(1, 1, 3'b010, 8'h00, 1, 0, 0, 0, 8'hA5, 0), "seq rst");
        check("rv0 q",    {24'd0, q2},    32'h0);
        check("rv0 zero", {31'd0, zero2}, 32'h1);
        check("rv0 wrap", {31'd0, wrap2}, 32'h0);
        check("rv0 qnot", {24'd0, qnot2}, 32'hFF);
        step(mk(0, 1, 3'b010, 8'h00, 0, 0, 0, 0, 8'h52, 0), "seq shr3");

        // Reset on a would-be wrapping edge must suppress the pulse.
        step(mk(0, 1, 3'b001, 8'hFF, 0, 0, 0, 0, 8'hFF, 0), "seq loadff");
        check("rv0 loadff q", {24'd0, q2}, 32'hFF);
        step(mk(1, 1, 3'b110, 8'h00, 0, 0, 0, 0, 8'hA5, 0), "seq rst inc");
        check("rv0 rst inc q",    {24'd0, q2},    32'h0);
        check("rv0 rst inc wrap", {31'd0, wrap2}, 32'h0);
        step(mk(0, 1, 3'b110, 8'h00, 0, 0, 0, 0, 8'hA6, 0), "seq inc");
        check("rv0 inc q", {24'd0, q2}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/registro_universal.md
Name: registro_universal

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, rising-edge register with synchronous reset, clock enable and eight operating modes.
- Modes: hold, parallel load, shift, rotate, increment and decrement.
- Provides true and complemented outputs, like the single flip-flop, plus serial outputs and a wrap flag.
- Serves as the general storage/serialiser/counter element for datapaths in the same design library.

Parameters:
- WIDTH, 8: register width in bits; must be ≥ 2.
- RESET_VAL, 0: value loaded into the register on reset; truncated to WIDTH bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  clock enable; when 0 the register holds regardless of mode.
- mode  input  3  operation select; codes listed under Behaviour.
- d  input  WIDTH  parallel load data.
- ser_in_r  input  1  serial input entering at the MSB during shift right.
- ser_in_l  input  1  serial input entering at the LSB during shift left.
- q  output  WIDTH  register state.
- qnot  output  WIDTH  bitwise complement of q.
- ser_out_r  output  1  q[0]; combinational from state.
- ser_out_l  output  1  q[WIDTH-1]; combinational from state.
- zero  output  1  1 when q == 0; combinational from state.
- wrap  output  1  registered pulse marking a counter wrap.

Behaviour:
- Clock and reset:
  - All state updates only on the rising edge of clk.
  - Reset is synchronous and active-high.
  - rst=1 at an edge: q <= RESET_VAL and wrap <= 0, regardless of en or mode. Reset has top priority.
  - After reset: qnot = ~RESET_VAL; zero = (RESET_VAL == 0).
- Clock enable:
  - With rst=0 and en=0: q holds and wrap <= 0.
- Modes (apply with rst=0, en=1), next value q+:
  - 000 hold: q+ = q.
  - 001 load: q+ = d.
  - 010 shift right: q+ = {ser_in_r, q[WIDTH-1:1]}.
  - 011 shift left: q+ = {q[WIDTH-2:0], ser_in_l}.
  - 100 rotate right: q+ = {q[0], q[WIDTH-1:1]}.
  - 101 rotate left: q+ = {q[WIDTH-2:0], q[WIDTH-1]}.
  - 110 increment: q+ = q + 1 modulo 2^WIDTH.
  - 111 decrement: q+ = q - 1 modulo 2^WIDTH.
- Latency and visibility:
  - Every update has one-cycle latency: the new q is visible after the edge.
  - qnot, ser_out_r, ser_out_l and zero follow q combinationally, with no extra latency.
- wrap flag:
  - Registered; asserted for exactly the one cycle following an enabled edge where mode=110 and q was all-ones, or mode=111 and q was 0.
  - Cleared on every other edge, including hold, en=0 and reset.
  - Back-to-back wraps (e.g. WIDTH consecutive decrements are impossible, but repeated inc from all-ones after load) produce a separate pulse per wrapping edge.
- Width rules:
  - Arithmetic is WIDTH bits with no saturation.
  - The carry/borrow appears only on wrap.
- Boundary conditions:
  - Shifts discard the bit shifted out. That bit was visible on ser_out_r or ser_out_l before the edge.
  - Mode may change every cycle; there is no multi-cycle state.
  - X or Z on unused serial inputs in non-shift modes must not affect q.
  - Reset asserted mid-sequence (e.g. during a run of shifts) overrides it in the same edge.
  - The sequence continues from RESET_VAL once rst drops.

Test Plan (WIDTH=8, RESET_VAL=8'hA5 unless stated):
- Reset and hold: rst=1 for 1 edge, then en=1, mode=000 for 3 edges -> q=8'hA5, qnot=8'h5A, zero=0, wrap=0 throughout.
- Load and shift right: load d=8'h81, then 8 shifts right with ser_in_r=1 -> q steps 8'hC0, 8'hE0 … 8'hFF. ser_out_r before each edge is 1,0,0,0,0,0,0,1.
- Rotate left: load 8'h81, rotate left ×1 -> 8'h03. After 8 rotates total -> 8'h81.
- Counter wrap: load 8'hFE, increment ×2 -> q=8'hFF then 8'h00. wrap=1 only in the cycle after the second edge, and zero=1. Then decrement -> q=8'hFF, wrap=1 for one cycle.
- Enable gating: load 8'h10, then en=0 with mode=110 for 4 edges -> q stays 8'h10, wrap=0.
- Reset priority: during shifts with en=1, assert rst for one edge -> q=8'hA5, wrap=0. With RESET_VAL=0 -> q=0, zero=1, no wrap pulse.
